// File: rtl/uart_mmio_pkg.sv
// Shared types and constants for the UART MMIO bridge.
package uart_mmio_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W      = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_mmio_bridge_if.sv
// CPU-facing MMIO UART signal bundle.
// master = CPU side, slave = bridge side.
interface uart_mmio_bridge_if;

  logic [7:0] mmio_uart_data_in;
  logic       mmio_uart_doorbell_flag;
  logic       mmio_uart_ack;
  logic [7:0] mmio_uart_data_out;
  logic       mmio_uart_tx_start;
  logic       mmio_uart_tx_busy;

  modport master (
    input  mmio_uart_data_in,
    input  mmio_uart_doorbell_flag,
    output mmio_uart_ack,
    output mmio_uart_data_out,
    output mmio_uart_tx_start,
    input  mmio_uart_tx_busy
  );

  modport slave (
    output mmio_uart_data_in,
    output mmio_uart_doorbell_flag,
    input  mmio_uart_ack,
    input  mmio_uart_data_out,
    input  mmio_uart_tx_start,
    output mmio_uart_tx_busy
  );

endinterface

// File: rtl/uart_mmio_fifo.sv
// Small synchronous FIFO for received UART bytes.
// Pop is honoured only when non-empty; a push while full succeeds only
// when a real pop happens in the same cycle, otherwise overflow pulses.
module uart_mmio_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_eff;
  logic             push_eff;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign overflow = push & full & ~pop_eff;
  assign head     = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; when full with a same-cycle pop, the slot being vacated is reused.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// UART <-> CPU MMIO bridge: RX deserializer into a FIFO, TX serializer.
// Optional macro UART_MMIO_LOOPBACK_EN feeds uart_tx back into the RX path.
module uart_mmio_bridge
  import uart_mmio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 234,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                uart_rx,
  output logic                uart_tx,
  uart_mmio_bridge_if.slave   mmio,
  output logic                rx_overrun,
  output logic                rx_frame_err,
  input  logic                err_clr
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(UART_DATA_BITS - 1);

  // ---------------- RX input selection and synchronizer ----------------
  logic rx_src;
  logic rx_meta;
  logic rx_s;

`ifdef UART_MMIO_LOOPBACK_EN
  logic unused_uart_rx;
  assign unused_uart_rx = uart_rx;
  assign rx_src         = uart_tx;
`else
  assign rx_src = uart_rx;
`endif

  // Two-stage synchronizer, idles high like the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_s    <= rx_meta;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t                 rx_state, rx_state_n;
  logic [CNT_W-1:0]          rx_cnt, rx_cnt_n;
  logic [BIT_CNT_W-1:0]      rx_bit, rx_bit_n;
  logic [UART_DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                      rx_block, rx_block_n;
  logic                      rx_push;
  logic                      rx_ferr_evt;

  // RX state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_block <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_block <= rx_block_n;
    end
  end

  // RX next-state: mid-start glitch check, then one sample per bit period.
  // rx_block keeps a stuck-low line after a framing error from re-arming.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_block_n  = rx_block;
    rx_push     = 1'b0;
    rx_ferr_evt = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        if (rx_block) begin
          if (rx_s) rx_block_n = 1'b0;
        end else if (!rx_s) begin
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[UART_DATA_BITS-1:1]};
          if (rx_bit == BIT_LAST) rx_state_n = RX_STOP;
          else                    rx_bit_n   = rx_bit + BIT_CNT_W'(1);
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          if (rx_s) begin
            rx_push = 1'b1;
          end else begin
            rx_ferr_evt = 1'b1;
            rx_block_n  = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0] fifo_head;
  logic       fifo_empty;
  logic       fifo_overflow;
  logic       unused_fifo_full;

  uart_mmio_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_rx_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (rx_push),
    .wdata    (rx_shift),
    .pop      (mmio.mmio_uart_ack),
    .head     (fifo_head),
    .full     (unused_fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_overflow)
  );

  assign mmio.mmio_uart_data_in       = fifo_head;
  assign mmio.mmio_uart_doorbell_flag = ~fifo_empty;

  // Sticky error flags; a new event outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (fifo_overflow) rx_overrun <= 1'b1;
      else if (err_clr)  rx_overrun <= 1'b0;
      if (rx_ferr_evt)   rx_frame_err <= 1'b1;
      else if (err_clr)  rx_frame_err <= 1'b0;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t                 tx_state, tx_state_n;
  logic [CNT_W-1:0]          tx_cnt, tx_cnt_n;
  logic [BIT_CNT_W-1:0]      tx_bit, tx_bit_n;
  logic [UART_DATA_BITS-1:0] tx_data, tx_data_n;
  logic                      tx_line_n;

  assign mmio.mmio_uart_tx_busy = (tx_state != TX_IDLE);

  // TX state register; the line is registered so it changes with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_data  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_data  <= tx_data_n;
      uart_tx  <= tx_line_n;
    end
  end

  // TX next-state: each phase lasts CLKS_PER_BIT clocks; line level follows next state.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_data_n  = tx_data;
    tx_line_n  = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        tx_bit_n = '0;
        if (mmio.mmio_uart_tx_start) begin
          tx_state_n = TX_START;
          tx_data_n  = mmio.mmio_uart_data_out;
        end
      end
      TX_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_DATA;
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == BIT_LAST) tx_state_n = TX_STOP;
          else                    tx_bit_n   = tx_bit + BIT_CNT_W'(1);
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    case (tx_state_n)
      TX_START: tx_line_n = 1'b0;
      TX_DATA:  tx_line_n = tx_data_n[tx_bit_n];
      default:  tx_line_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge with an expected-byte queue for RX.
module tb_uart_mmio_bridge;
  import uart_mmio_pkg::*;

  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic uart_rx;
  logic uart_tx;
  logic rx_overrun;
  logic rx_frame_err;
  logic err_clr;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_mmio_bridge_if bus();

  always #5 clk = ~clk;

  uart_mmio_bridge #(
    .CLKS_PER_BIT  (CPB),
    .RX_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .uart_tx      (uart_tx),
    .mmio         (bus),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .err_clr      (err_clr)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rx_level(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_level(1'b0);
    for (int i = 0; i < 8; i++) rx_level(b[i]);
    rx_level(stop);
    uart_rx = 1'b1;
  endtask

  // Compare the FIFO head against the oldest expected byte, then ack it.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = 8'hxx;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check8(tag, bus.mmio_uart_data_in, e);
    bus.mmio_uart_ack = 1'b1;
    @(negedge clk);
    bus.mmio_uart_ack = 1'b0;
  endtask

  task automatic pulse_tx(input logic [7:0] d);
    bus.mmio_uart_data_out = d;
    bus.mmio_uart_tx_start = 1'b1;
    @(negedge clk);
    bus.mmio_uart_tx_start = 1'b0;
  endtask

  initial begin
    reset                  = 1'b1;
    uart_rx                = 1'b1;
    err_clr                = 1'b0;
    bus.mmio_uart_ack      = 1'b0;
    bus.mmio_uart_data_out = 8'h00;
    bus.mmio_uart_tx_start = 1'b0;
    repeat (3) @(negedge clk);

    check1("rst_uart_tx", uart_tx, 1'b1);
    check8("rst_data_in", bus.mmio_uart_data_in, 8'h00);
    check1("rst_doorbell", bus.mmio_uart_doorbell_flag, 1'b0);
    check1("rst_tx_busy", bus.mmio_uart_tx_busy, 1'b0);
    check1("rst_overrun", rx_overrun, 1'b0);
    check1("rst_frame_err", rx_frame_err, 1'b0);

    reset = 1'b0;
    repeat (4) @(negedge clk);

`ifdef UART_MMIO_LOOPBACK_EN
    pulse_tx(8'hC3);
    exp_q.push_back(8'hC3);
    for (int n = 0; n < 20 * CPB && bus.mmio_uart_doorbell_flag !== 1'b1; n++) @(negedge clk);
    check1("lb_doorbell", bus.mmio_uart_doorbell_flag, 1'b1);
    pop_check("lb_data");
    check1("lb_drained", bus.mmio_uart_doorbell_flag, 1'b0);
`else
    // Single frame 0xA5: doorbell appears exactly one cycle after the stop sample.
    rx_level(1'b0);
    for (int i = 0; i < 8; i++) rx_level(((8'hA5 >> i) & 8'h01) != 8'h00);
    uart_rx = 1'b1;
    repeat (6) @(negedge clk);
    check1("a5_doorbell_early", bus.mmio_uart_doorbell_flag, 1'b0);
    @(negedge clk);
    check1("a5_doorbell", bus.mmio_uart_doorbell_flag, 1'b1);
    exp_q.push_back(8'hA5);
    pop_check("a5_data");
    check1("a5_doorbell_after_ack", bus.mmio_uart_doorbell_flag, 1'b0);
    check8("a5_data_after_ack", bus.mmio_uart_data_in, 8'h00);
    repeat (4) @(negedge clk);

    // Five frames into a four-deep FIFO: fifth is dropped.
    for (int b = 1; b <= 5; b++) begin
      send_rx(8'(b), 1'b1);
      if (b <= int'(DEPTH)) exp_q.push_back(8'(b));
    end
    @(negedge clk);
    check1("ovr_flag", rx_overrun, 1'b1);
    check1("ovr_no_frame_err", rx_frame_err, 1'b0);
    for (int k = 0; k < int'(DEPTH); k++) pop_check("ovr_pop");
    check1("ovr_drained", bus.mmio_uart_doorbell_flag, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check1("ovr_cleared", rx_overrun, 1'b0);

    // TX 0x3C with a second start request mid-frame that must be ignored.
    begin
      logic [9:0] pat;
      pat = 10'b1001111000;
      pulse_tx(8'h3C);
      for (int i = 0; i < 10 * int'(CPB); i++) begin
        check1("tx_line", uart_tx, pat[i / int'(CPB)]);
        check1("tx_busy", bus.mmio_uart_tx_busy, 1'b1);
        if (i == 30) begin
          bus.mmio_uart_data_out = 8'hFF;
          bus.mmio_uart_tx_start = 1'b1;
        end else begin
          bus.mmio_uart_tx_start = 1'b0;
        end
        @(negedge clk);
      end
      check1("tx_busy_done", bus.mmio_uart_tx_busy, 1'b0);
      check1("tx_line_idle", uart_tx, 1'b1);
    end
    repeat (4) @(negedge clk);

    // Framing error on 0x55, then a clean 0x12.
    send_rx(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check1("ferr_no_doorbell", bus.mmio_uart_doorbell_flag, 1'b0);
    check1("ferr_flag", rx_frame_err, 1'b1);
    send_rx(8'h12, 1'b1);
    exp_q.push_back(8'h12);
    @(negedge clk);
    check1("ferr_next_doorbell", bus.mmio_uart_doorbell_flag, 1'b1);
    pop_check("ferr_next_data");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check1("ferr_cleared", rx_frame_err, 1'b0);

    // Two-clock low glitch is rejected; a following frame still works.
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check1("glitch_no_doorbell", bus.mmio_uart_doorbell_flag, 1'b0);
    check1("glitch_idle", dut.rx_state == RX_IDLE, 1'b1);
    send_rx(8'h7E, 1'b1);
    exp_q.push_back(8'h7E);
    @(negedge clk);
    pop_check("glitch_next_data");

    // Reset in the middle of a TX frame.
    pulse_tx(8'h00);
    repeat (20) @(negedge clk);
    check1("midtx_line_low", uart_tx, 1'b0);
    check1("midtx_busy", bus.mmio_uart_tx_busy, 1'b1);
    reset = 1'b1;
    #1;
    check1("rst_midtx_line", uart_tx, 1'b1);
    check1("rst_midtx_busy", bus.mmio_uart_tx_busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check1("post_rst_busy", bus.mmio_uart_tx_busy, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
Peripheral-side endpoint of the CPU's MMIO UART interface. It drives the CPU-facing receive byte and doorbell flag, and it consumes the CPU-facing transmit byte.
- RX path: deserializes the board serial RX line into a small FIFO.
- TX path: serializes bytes written by the CPU onto the serial TX line.
- Sits at top level between the board UART pins and the computer's MMIO UART ports.

Parameters:
- CLKS_PER_BIT, 234, clocks per serial bit (27 MHz / 115200); must be >= 4.
- RX_FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- uart_rx  input  1  serial RX pin, asynchronous to clk
- uart_tx  output  1  serial TX pin
- mmio_uart_data_in  output  8  RX FIFO head byte presented to the CPU
- mmio_uart_doorbell_flag  output  1  high while the RX FIFO is non-empty
- mmio_uart_ack  input  1  one-cycle pulse; pops the RX FIFO head
- mmio_uart_data_out  input  8  byte from the CPU to transmit
- mmio_uart_tx_start  input  1  one-cycle pulse; requests transmission of mmio_uart_data_out
- mmio_uart_tx_busy  output  1  TX frame in progress
- rx_overrun  output  1  sticky: a byte was dropped because the FIFO was full
- rx_frame_err  output  1  sticky: a stop bit was sampled low
- err_clr  input  1  clears both sticky flags

Behaviour:
- Reset, asynchronous active-high. All outputs take their reset values immediately and hold them while reset is asserted:
  - uart_tx = 1
  - mmio_uart_data_in = 0, doorbell = 0, tx_busy = 0
  - rx_overrun = 0, rx_frame_err = 0
  - FIFO emptied; both FSMs return to IDLE; any in-flight frame is abandoned (TX line returns high).
- RX input conditioning: uart_rx passes through a 2-FF synchronizer, reset value 1.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: synchronized rx low -> START, counter cleared.
  - START: at CLKS_PER_BIT/2 (integer division), re-sample. Low -> DATA. High -> IDLE (glitch rejection, nothing pushed).
  - DATA: sample every CLKS_PER_BIT clocks; 8 bits, LSB first, shifted into a byte register. After bit 7 -> STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - High: push the byte into the FIFO.
    - Low: discard the byte, set rx_frame_err.
    - Either case -> IDLE. Framing-error path waits for rx high before re-arming.
- RX FIFO:
  - doorbell = !empty.
  - mmio_uart_data_in = head byte when non-empty, 0 when empty.
  - Latency: the push happens on the stop-sample cycle; doorbell and data are visible on the next cycle.
  - ack pops one entry. Ack while empty is ignored.
  - Push while full without a same-cycle ack: byte dropped, rx_overrun set.
  - Push and ack in the same cycle while full: pop then push, no overrun.
  - Push and ack in the same cycle while empty: ack ignored, push occurs.
  - Pointers wrap modulo RX_FIFO_DEPTH; occupancy counter is log2(depth)+1 bits.
- Sticky flags: err_clr clears them. err_clr in the same cycle as a new error event: set wins.
- TX FSM states: IDLE, START, DATA, STOP.
  - tx_start while IDLE: latch mmio_uart_data_out; tx_busy goes high the next cycle.
  - tx_start while busy: ignored; no queueing.
  - Frame timing: start bit (0) for CLKS_PER_BIT clocks, then 8 data bits LSB first, then stop bit (1) for CLKS_PER_BIT clocks.
  - Total frame = 10*CLKS_PER_BIT clocks.
  - tx_busy drops on the cycle after the stop bit completes. A new tx_start is accepted in that same cycle.
- RX and TX are fully independent; simultaneous operation is required.

Optional Feature:
- Macro UART_MMIO_LOOPBACK_EN.
- Defined: the RX synchronizer input is the internal uart_tx instead of the uart_rx pin. uart_rx is ignored. The uart_tx pin still toggles normally.
- Undefined: normal pin operation, with no loopback logic present.

Decomposition:
- Package uart_mmio_pkg:
  - rx_state_t and tx_state_t enums (IDLE, START, DATA, STOP).
  - UART_DATA_BITS = 8.
  - Bit-counter width constant.
- Sub-module uart_mmio_fifo:
  - Parameterized by depth and width.
  - Push/pop/full/empty/head interface.
  - Implements the simultaneous push/pop rules above.
- Both FSMs remain in uart_mmio_bridge.

Test Plan:
- CLKS_PER_BIT=8. Drive RX frame 0xA5 -> doorbell rises one cycle after the stop sample, data_in=0xA5. Pulse ack -> doorbell=0, data_in=0.
- Drive 5 RX frames 0x01..0x05 with no ack, depth 4 -> rx_overrun=1. Four acks pop 0x01..0x04 in order. err_clr -> rx_overrun=0.
- tx_start with data_out=0x3C -> uart_tx pattern 0,0,0,1,1,1,1,0,0,1, each level held 8 clocks. tx_busy high for 80 clocks. A second tx_start mid-frame is ignored.
- RX frame 0x55 with the stop bit forced low -> no doorbell, rx_frame_err=1. A following valid frame 0x12 is received correctly.
- 2-clock low glitch on uart_rx -> no push, FSM back in IDLE. Assert reset mid-TX frame -> uart_tx=1 and tx_busy=0 immediately.
- With UART_MMIO_LOOPBACK_EN defined: tx_start 0xC3 -> after one frame time plus sync delay, doorbell=1 and data_in=0xC3.
